ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 161 ++++++++++++++++
 tb/tb_ex_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of a Y86-style pipeline: ALU, condition codes, branch/cmov condition and EX/MEM register.
// Optional halt FSM (RUN/HALTED) is compiled in when EX_HALT_EN is defined.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        bubble,
  input  logic [3:0]  id_icode,
  input  logic [3:0]  id_ifun,
  input  logic [31:0] id_valA,
  input  logic [31:0] id_valB,
  input  logic [31:0] id_valC,
  input  logic [31:0] id_valP,
  input  logic [3:0]  id_dstE,
  input  logic [3:0]  id_dstM,
  output logic [3:0]  ex_icode,
  output logic [31:0] ex_valE,
  output logic [31:0] ex_valA,
  output logic [31:0] ex_valP,
  output logic [3:0]  ex_dstE,
  output logic [3:0]  ex_dstM,
  output logic        ex_Cnd,
  output logic [2:0]  cc,
  output logic        ex_halted
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] I_NOP    = 4'h1;

  logic [31:0] alu_res;
  logic        alu_of;
  logic [31:0] val_e;
  logic        cnd;
  logic        invalid;
  logic        accept;
  logic        halted;
  logic        load_bubble;
  logic        cc_we;
  logic [2:0]  cc_next;
  logic [3:0]  dst_e_next;
  logic [3:0]  dst_m_next;
  logic        cnd_next;

  assign accept = !stall && !bubble && !halted;

  // Halt and undefined encodings; same set in both builds.
  assign invalid = (id_icode == 4'h0) || (id_icode > 4'hB) ||
                   ((id_icode == 4'h6) && (id_ifun > 4'h3)) ||
                   (((id_icode == 4'h2) || (id_icode == 4'h7)) && (id_ifun > 4'h6));

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (id_ifun)
      4'h0: begin
        alu_res = id_valB + id_valA;
        alu_of  = (id_valB[31] == id_valA[31]) && (alu_res[31] != id_valB[31]);
      end
      4'h1: begin
        alu_res = id_valB - id_valA;
        alu_of  = (id_valB[31] != id_valA[31]) && (alu_res[31] != id_valB[31]);
      end
      4'h2:    alu_res = id_valB & id_valA;
      4'h3:    alu_res = id_valB ^ id_valA;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    val_e = '0;
    case (id_icode)
      4'h2:       val_e = id_valA;
      4'h3:       val_e = id_valC;
      4'h4, 4'h5: val_e = id_valB + id_valC;
      4'h6:       val_e = alu_res;
      4'h8, 4'hA: val_e = id_valB - 32'd4;
      4'h9, 4'hB: val_e = id_valB + 32'd4;
      default:    val_e = '0;
    endcase
  end

  // Condition uses the cc value held before this instruction's own update.
  always_comb begin
    cnd = 1'b0;
    case (id_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (cc[1] ^ cc[0]) | cc[2];
      4'h2:    cnd = cc[1] ^ cc[0];
      4'h3:    cnd = cc[2];
      4'h4:    cnd = !cc[2];
      4'h5:    cnd = !(cc[1] ^ cc[0]);
      4'h6:    cnd = !(cc[1] ^ cc[0]) && !cc[2];
      default: cnd = 1'b0;
    endcase
  end

  always_comb begin
    cnd_next   = ((id_icode == 4'h2) || (id_icode == 4'h7)) ? cnd : 1'b0;
    dst_e_next = ((id_icode == 4'h2) && !cnd) ? REG_NONE : id_dstE;
    dst_m_next = id_dstM;
    if (invalid) begin
      cnd_next   = 1'b0;
      dst_e_next = REG_NONE;
      dst_m_next = REG_NONE;
    end
  end

  assign cc_we       = accept && (id_icode == 4'h6) && !invalid;
  assign cc_next     = {(alu_res == 32'd0), alu_res[31], alu_of};
  assign load_bubble = halted || (!stall && bubble);

`ifdef EX_HALT_EN
  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;
  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (accept && invalid) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    halted    = (state == ST_HALTED);
    ex_halted = halted;
  end
`else
  assign halted    = 1'b0;
  assign ex_halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      ex_icode <= I_NOP;
      ex_valE  <= '0;
      ex_valA  <= '0;
      ex_valP  <= '0;
      ex_dstE  <= REG_NONE;
      ex_dstM  <= REG_NONE;
      ex_Cnd   <= 1'b0;
      if (rst) cc <= 3'b100;
    end else if (!stall) begin
      ex_icode <= id_icode;
      ex_valE  <= invalid ? 32'd0 : val_e;
      ex_valA  <= id_valA;
      ex_valP  <= id_valP;
      ex_dstE  <= dst_e_next;
      ex_dstM  <= dst_m_next;
      ex_Cnd   <= cnd_next;
      if (cc_we) cc <= cc_next;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus random traffic against a reference model.
// Halt scenarios run when EX_HALT_EN is defined for both bench and design.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, bubble;
  logic [3:0]  id_icode, id_ifun, id_dstE, id_dstM;
  logic [31:0] id_valA, id_valB, id_valC, id_valP;
  logic [3:0]  ex_icode, ex_dstE, ex_dstM;
  logic [31:0] ex_valE, ex_valA, ex_valP;
  logic        ex_Cnd, ex_halted;
  logic [2:0]  cc;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  icode;
    logic [31:0] val_e;
    logic [31:0] val_a;
    logic [31:0] val_p;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        cnd;
    logic [2:0]  cc;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .id_icode(id_icode), .id_ifun(id_ifun),
    .id_valA(id_valA), .id_valB(id_valB), .id_valC(id_valC), .id_valP(id_valP),
    .id_dstE(id_dstE), .id_dstM(id_dstM),
    .ex_icode(ex_icode), .ex_valE(ex_valE), .ex_valA(ex_valA), .ex_valP(ex_valP),
    .ex_dstE(ex_dstE), .ex_dstM(ex_dstM), .ex_Cnd(ex_Cnd), .cc(cc), .ex_halted(ex_halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t bubble_of(input exp_t cur);
    exp_t r = cur;
    r.icode = 4'h1; r.val_e = '0; r.val_a = '0; r.val_p = '0;
    r.dst_e = 4'hF; r.dst_m = 4'hF; r.cnd = 1'b0;
    return r;
  endfunction

  // Reference model of one clock edge.
  function automatic exp_t model(input exp_t cur, input logic r, s, b,
                                 input logic [3:0] ic, fn,
                                 input logic [31:0] a, bv, c, p,
                                 input logic [3:0] de, dm);
    exp_t n = cur;
    logic zf, sf, of_, cond, bad;
    logic [32:0] wide;
    logic [31:0] res;
    zf = cur.cc[2]; sf = cur.cc[1]; of_ = cur.cc[0];
    if (r) begin
      n = bubble_of(cur); n.cc = 3'b100; n.halted = 1'b0;
      return n;
    end
    if (cur.halted) return bubble_of(cur);
    if (s) return cur;
    if (b) return bubble_of(cur);
    bad = (ic == 0) || (ic > 11) || (ic == 6 && fn > 3) || ((ic == 2 || ic == 7) && fn > 6);
    case (fn)
      0: cond = 1'b1;
      1: cond = (sf != of_) || zf;
      2: cond = (sf != of_);
      3: cond = zf;
      4: cond = !zf;
      5: cond = (sf == of_);
      6: cond = (sf == of_) && !zf;
      default: cond = 1'b0;
    endcase
    res = 0;
    case (ic)
      2: res = a;
      3: res = c;
      4, 5: res = bv + c;
      6: case (fn)
           0: res = bv + a;
           1: res = bv - a;
           2: res = bv & a;
           3: res = bv ^ a;
           default: res = 0;
         endcase
      8, 10: res = bv - 4;
      9, 11: res = bv + 4;
      default: res = 0;
    endcase
    n.icode = ic; n.val_a = a; n.val_p = p; n.dst_m = dm;
    n.val_e = res;
    n.cnd = (ic == 2 || ic == 7) ? cond : 1'b0;
    n.dst_e = (ic == 2 && !cond) ? 4'hF : de;
    if (bad) begin
      n.val_e = 0; n.dst_e = 4'hF; n.dst_m = 4'hF; n.cnd = 1'b0;
`ifdef EX_HALT_EN
      n.halted = 1'b1;
`endif
    end else if (ic == 6) begin
      n.cc[2] = (res == 0);
      n.cc[1] = res[31];
      if (fn == 0) begin
        wide = {1'b0, bv} + {1'b0, a};
        n.cc[0] = ($signed(bv) >= 0 && $signed(a) >= 0 && res[31]) ||
                  ($signed(bv) < 0 && $signed(a) < 0 && !res[31]);
      end else if (fn == 1) begin
        wide = {1'b0, bv} - {1'b0, a};
        n.cc[0] = ($signed(bv) >= 0 && $signed(a) < 0 && res[31]) ||
                  ($signed(bv) < 0 && $signed(a) >= 0 && !res[31]);
      end else begin
        wide = '0;
        n.cc[0] = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic drive(input logic r, s, b, input logic [3:0] ic, fn,
                       input logic [31:0] a, bv, c, p, input logic [3:0] de, dm);
    exp_t e;
    rst = r; stall = s; bubble = b;
    id_icode = ic; id_ifun = fn; id_valA = a; id_valB = bv; id_valC = c; id_valP = p;
    id_dstE = de; id_dstM = dm;
    m = model(m, r, s, b, ic, fn, a, bv, c, p, de, dm);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("icode", ex_icode, e.icode);
    check("valE", ex_valE, e.val_e);
    check("valA", ex_valA, e.val_a);
    check("valP", ex_valP, e.val_p);
    check("dstE", ex_dstE, e.dst_e);
    check("dstM", ex_dstM, e.dst_m);
    check("cnd", ex_Cnd, e.cnd);
    check("cc", cc, e.cc);
    check("halted", ex_halted, e.halted);
  endtask

  task automatic op(input logic [3:0] ic, fn, input logic [31:0] a, bv, c, input logic [3:0] de, dm);
    drive(1'b0, 1'b0, 1'b0, ic, fn, a, bv, c, 32'h100, de, dm);
  endtask

  initial begin
    m = '0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b1, 4'h6, 4'h0, 1, 2, 3, 4, 4'h1, 4'h2);
    drive(1'b1, 1'b0, 1'b0, 4'h3, 4'h0, 0, 0, 0, 0, 4'h0, 4'hF);
    check("reset_cc", cc, 3'b100);
    check("reset_icode", ex_icode, 4'h1);

    op(4'h3, 4'h0, 0, 0, 32'h12345678, 4'h0, 4'hF);
    check("irmovl_valE", ex_valE, 32'h12345678);
    check("irmovl_dstE", ex_dstE, 4'h0);
    op(4'h6, 4'h1, 5, 5, 0, 4'h2, 4'hF);
    check("sub_zero_cc", cc, 3'b100);
    op(4'h6, 4'h0, 1, 32'h7FFFFFFF, 0, 4'h2, 4'hF);
    check("add_ovf_valE", ex_valE, 32'h80000000);
    check("add_ovf_cc", cc, 3'b011);
    op(4'h7, 4'h2, 0, 0, 32'h40, 4'hF, 4'hF);
    check("jl_cnd", ex_Cnd, 1'b0);
    op(4'h2, 4'h4, 32'hAA, 0, 0, 4'h3, 4'hF);
    check("cmovne_cnd", ex_Cnd, 1'b1);
    check("cmovne_dstE", ex_dstE, 4'h3);
    op(4'h2, 4'h3, 32'hAA, 0, 0, 4'h3, 4'hF);
    check("cmove_dstE", ex_dstE, 4'hF);

    drive(1'b0, 1'b1, 1'b0, 4'h6, 4'h1, 9, 3, 0, 7, 4'h4, 4'h5);
    drive(1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 1, 2, 3, 8, 4'h6, 4'h7);
    check("stall_cc", cc, 3'b011);
    drive(1'b0, 1'b1, 1'b1, 4'h6, 4'h0, 0, 0, 0, 9, 4'h1, 4'h1);
    drive(1'b0, 1'b0, 1'b1, 4'h6, 4'h0, 0, 0, 0, 9, 4'h1, 4'h1);
    check("bubble_icode", ex_icode, 4'h1);
    check("bubble_dstM", ex_dstM, 4'hF);

    op(4'h6, 4'h2, 32'hF0F0, 32'h0F0F, 0, 4'h1, 4'hF);
    op(4'h6, 4'h3, 32'h1234, 32'h1234, 0, 4'h1, 4'hF);
    op(4'hA, 4'h0, 0, 32'h200, 0, 4'h4, 4'hF);
    op(4'hB, 4'h0, 0, 32'h1FC, 0, 4'h4, 4'h6);
    op(4'h4, 4'h0, 32'h5, 32'h8, 32'h10, 4'hF, 4'hF);
    op(4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF);

`ifdef EX_HALT_EN
    op(4'h0, 4'h0, 0, 0, 0, 4'h1, 4'h2);
    check("halt_icode", ex_icode, 4'h0);
    op(4'h6, 4'h0, 1, 1, 0, 4'h1, 4'hF);
    check("halted_flag", ex_halted, 1'b1);
    check("halted_icode", ex_icode, 4'h1);
    drive(1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 0, 0, 0, 0, 4'hF, 4'hF);
    check("halt_reset_flag", ex_halted, 1'b0);
    check("halt_reset_cc", cc, 3'b100);
`else
    op(4'h0, 4'h0, 0, 0, 0, 4'h1, 4'h2);
    check("nohalt_dstM", ex_dstM, 4'hF);
    check("nohalt_flag", ex_halted, 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, bv;
      a  = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) bv = {bv[31], 31'h7FFFFFF0} + $urandom_range(0, 31);
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            ($urandom_range(0, 3) == 0) ? 4'h6 : 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 7)), a, bv, $urandom, $urandom,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
